ppc_ebi_bridge: RTL and testbench
=================================

Name: ppc_ebi_bridge

Overview:
Parametrised PowerPC EBI slave bridge. Sits between the asynchronous external bus (cs_n/oe_n/we_n/rd_wr, A-lines, D-lines) and the FPGA register/memory back end in the dual-core system. Synchronises the bus strobes and decodes a configurable address window. Issues exactly one single-cycle read or write request per bus cycle, with captured address, data and byte enables. Returns read data through a ready/timeout handshake and holds it for the bus.

Parameters:
ADDR_W, 24, EBI address lines connected (A31..A8); word address is ebi_addr[ADDR_W-1:2]
DATA_W, 32, data bus width
BE_W, 4, number of we_n byte strobes (DATA_W/8)
SYNC_STAGES, 2, flip-flop stages on cs_n/oe_n/we_n/rd_wr (min 2)
WIN_MASK, 22'h002000, word-address bits compared for window decode
WIN_MATCH, 22'h000000, required value of masked bits (hit when (addr & WIN_MASK)==WIN_MATCH)
TIMEOUT, 16, cycles to wait for rvalid_i before error completion (min 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
cs_n  in  1  EBI chip select, active low, asynchronous
oe_n  in  1  EBI output enable, active low, asynchronous
we_n  in  BE_W  EBI byte write enables, active low, asynchronous
rd_wr  in  1  1 = read, 0 = write
ebi_addr  in  ADDR_W  EBI address
ebi_wdata  in  DATA_W  EBI write data
ebi_rdata  out  DATA_W  registered read data to bus
ebi_rdata_oe  out  1  tristate enable for ebi_rdata
addr  out  ADDR_W-2  captured word address
wdata  out  DATA_W  captured write data
be  out  BE_W  captured byte enables (~we_n)
re_o  out  1  one-cycle read request
we_o  out  1  one-cycle write request
rdata_i  in  DATA_W  back-end read data
rvalid_i  in  1  back-end read data valid
err_o  out  1  one-cycle pulse: timeout or abort

Behaviour:
- Reset: state IDLE; sync flops load inactive (cs_n=1, oe_n=1, we_n=all 1, rd_wr=1); all outputs 0; timeout counter 0.
- Synced conditions: wr_c = ~cs_s & ~rd_wr_s & (we_s != all 1); rd_c = ~cs_s & rd_wr_s & (we_s == all 1).
- IDLE: on wr_c with hit -> capture addr, wdata, be=~we_s; assert we_o for 1 cycle (the cycle after the capture edge); go DONE.
- IDLE: on rd_c with hit -> capture addr; pulse re_o 1 cycle; clear counter; go RWAIT.
- IDLE: wr_c/rd_c without hit -> no pulse; go DONE.
- RWAIT: rvalid_i=1 -> ebi_rdata<=rdata_i, rd_ok<=1, go DONE. rvalid_i in the same cycle as the re_o pulse is accepted.
- RWAIT: counter reaches TIMEOUT-1 without rvalid_i -> ebi_rdata<=all 1s, rd_ok<=1, err_o pulse, go DONE.
- RWAIT: cs_s deasserts -> err_o pulse, go IDLE, ebi_rdata unchanged. Abort has priority over rvalid_i in the same cycle.
- DONE: wait for cs_s=1, then go IDLE and clear rd_ok. Exactly one request per cs_n low period, however long.
- ebi_rdata_oe = rd_ok & ~oe_s & ~cs_s (registered); deasserts 1 cycle after synced oe_n or cs_n rises.
- Latency: strobe condition valid at synchronizer output on edge k -> re_o/we_o high in cycle k+1. Total latency is SYNC_STAGES+1 edges from the first sampling edge.
- addr/wdata/be hold their values until the next capture. rvalid_i is ignored outside RWAIT.
- rst asserted mid-transaction -> immediate return to reset values; no pulse completes.

Test Plan:
- Write hit: ebi_addr=24'h000104, we_n=4'b0000, rd_wr=0, ebi_wdata=32'hDEADBEEF, cs_n low 10 cycles -> single we_o pulse at edge 3, addr=22'h41, wdata=32'hDEADBEEF, be=4'hF.
- Byte write: we_n=4'b1101 -> be=4'b0010, one we_o; long cs_n (50 cycles) still gives exactly one pulse.
- Read with ready: rd_wr=1, oe_n low, addr 22'h10, rvalid_i 3 cycles after re_o with rdata_i=32'h12345678 -> ebi_rdata=32'h12345678, ebi_rdata_oe=1 until oe_n sync rises +1 cycle.
- Window miss: word addr bit13=1 (ebi_addr=24'h008000) read and write -> no re_o/we_o, ebi_rdata_oe stays 0.
- Timeout: read hit, rvalid_i never asserted -> err_o pulse TIMEOUT cycles after re_o, ebi_rdata=32'hFFFFFFFF driven while oe_n low.
- Abort/reset: cs_n rises during RWAIT -> err_o pulse, IDLE, no oe; rst mid-RWAIT -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ppc_ebi_bridge_if.sv
// EBI pin-side bundle of the PowerPC bridge: strobes, address and data lines.
// The processor drives the master side; the bridge sits on the slave side.
interface ppc_ebi_bridge_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic              cs_n;
  logic              oe_n;
  logic [BE_W-1:0]   we_n;
  logic              rd_wr;
  logic [ADDR_W-1:0] ebi_addr;
  logic [DATA_W-1:0] ebi_wdata;
  logic [DATA_W-1:0] ebi_rdata;
  logic              ebi_rdata_oe;

  modport master (
    output cs_n, oe_n, we_n, rd_wr, ebi_addr, ebi_wdata,
    input  ebi_rdata, ebi_rdata_oe
  );

  modport slave (
    input  cs_n, oe_n, we_n, rd_wr, ebi_addr, ebi_wdata,
    output ebi_rdata, ebi_rdata_oe
  );
endinterface

// File: rtl/ppc_ebi_bridge.sv
// PowerPC EBI slave bridge: synchronises bus strobes, decodes an address window and
// issues one single-cycle read/write request per chip-select period to the back end.
module ppc_ebi_bridge #(
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 32,
  parameter int                BE_W        = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [ADDR_W-3:0] WIN_MASK    = 22'h002000,
  parameter logic [ADDR_W-3:0] WIN_MATCH   = 22'h000000,
  parameter int                TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  ppc_ebi_bridge_if.slave     ebi,
  output logic [ADDR_W-3:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [BE_W-1:0]     be,
  output logic                re_o,
  output logic                we_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                rvalid_i,
  output logic                err_o
);
  localparam int SW    = BE_W + 3;
  localparam int AW    = ADDR_W - 2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RWAIT, DONE} state_t;

  // Strobes packed as {rd_wr, we_n, oe_n, cs_n}; all-ones is the idle bus.
  logic [SW-1:0] sync_in;
  logic [SW-1:0] sync_reg [SYNC_STAGES];

  assign sync_in = {ebi.rd_wr, ebi.we_n, ebi.oe_n, ebi.cs_n};

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= '1;
          else     sync_reg[gi] <= sync_in;
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= '1;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic            cs_s, oe_s, rd_wr_s;
  logic [BE_W-1:0] we_s;
  logic            wr_c, rd_c, hit;
  logic [AW-1:0]   word_addr;

  assign cs_s      = sync_reg[SYNC_STAGES-1][0];
  assign oe_s      = sync_reg[SYNC_STAGES-1][1];
  assign we_s      = sync_reg[SYNC_STAGES-1][BE_W+1:2];
  assign rd_wr_s   = sync_reg[SYNC_STAGES-1][SW-1];
  assign wr_c      = ~cs_s & ~rd_wr_s & (we_s != '1);
  assign rd_c      = ~cs_s & rd_wr_s & (we_s == '1);
  // Address and write data are assumed stable once the synced strobes qualify them.
  assign word_addr = ebi.ebi_addr[ADDR_W-1:2];
  assign hit       = (word_addr & WIN_MASK) == WIN_MATCH;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [AW-1:0]     addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [BE_W-1:0]   be_reg, be_next;
  logic              re_reg, re_next;
  logic              we_reg, we_next;
  logic              err_reg, err_next;
  logic              rd_ok_reg, rd_ok_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              rdata_oe_reg, rdata_oe_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      be_reg       <= '0;
      re_reg       <= 1'b0;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      rd_ok_reg    <= 1'b0;
      rdata_reg    <= '0;
      rdata_oe_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      be_reg       <= be_next;
      re_reg       <= re_next;
      we_reg       <= we_next;
      err_reg      <= err_next;
      rd_ok_reg    <= rd_ok_next;
      rdata_reg    <= rdata_next;
      rdata_oe_reg <= rdata_oe_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    be_next       = be_reg;
    re_next       = 1'b0;
    we_next       = 1'b0;
    err_next      = 1'b0;
    rd_ok_next    = rd_ok_reg;
    rdata_next    = rdata_reg;
    rdata_oe_next = rd_ok_reg & ~oe_s & ~cs_s;

    case (state_reg)
      IDLE: begin
        if (wr_c) begin
          if (hit) begin
            addr_next  = word_addr;
            wdata_next = ebi.ebi_wdata;
            be_next    = ~we_s;
            we_next    = 1'b1;
          end
          state_next = DONE;
        end else if (rd_c) begin
          if (hit) begin
            addr_next  = word_addr;
            re_next    = 1'b1;
            cnt_next   = '0;
            state_next = RWAIT;
          end else begin
            state_next = DONE;
          end
        end
      end
      RWAIT: begin
        // Bus abort wins over a late rvalid_i or timeout in the same cycle.
        if (cs_s) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (rvalid_i) begin
          rdata_next = rdata_i;
          rd_ok_next = 1'b1;
          state_next = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          rdata_next = '1;
          rd_ok_next = 1'b1;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        // Hold here until chip select drops so a long cycle yields only one request.
        if (cs_s) begin
          rd_ok_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr             = addr_reg;
  assign wdata            = wdata_reg;
  assign be               = be_reg;
  assign re_o             = re_reg;
  assign we_o             = we_reg;
  assign err_o            = err_reg;
  assign ebi.ebi_rdata    = rdata_reg;
  assign ebi.ebi_rdata_oe = rdata_oe_reg;
endmodule

// File: tb/tb_ppc_ebi_bridge.sv
// Directed self-checking bench for ppc_ebi_bridge: write/read hits, window miss,
// timeout, bus abort and mid-transaction reset.
module tb_ppc_ebi_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        re_o, we_o, err_o;
  logic [31:0] rdata_i;
  logic        rvalid_i;

  int errors = 0;
  int checks = 0;
  int we_cnt, re_cnt, err_cnt, oe_seen;

  ppc_ebi_bridge_if bus ();

  ppc_ebi_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .ebi      (bus),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .re_o     (re_o),
    .we_o     (we_o),
    .rdata_i  (rdata_i),
    .rvalid_i (rvalid_i),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      we_cnt  += int'(we_o);
      re_cnt  += int'(re_o);
      err_cnt += int'(err_o);
      oe_seen += int'(bus.ebi_rdata_oe);
    end
  endtask

  task automatic clr();
    we_cnt = 0; re_cnt = 0; err_cnt = 0; oe_seen = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cs_n = 1'b1; bus.oe_n = 1'b1; bus.we_n = 4'hF; bus.rd_wr = 1'b1;
  endtask

  task automatic start_read(input logic [23:0] a);
    bus.ebi_addr = a; bus.rd_wr = 1'b1; bus.we_n = 4'hF; bus.oe_n = 1'b0; bus.cs_n = 1'b0;
  endtask

  task automatic start_write(input logic [23:0] a, input logic [3:0] wen, input logic [31:0] d);
    bus.ebi_addr = a; bus.rd_wr = 1'b0; bus.we_n = wen; bus.ebi_wdata = d; bus.oe_n = 1'b1; bus.cs_n = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_idle(); bus.ebi_addr = '0; bus.ebi_wdata = '0;
    rdata_i = '0; rvalid_i = 1'b0; clr();
    step(3);
    chk("rst_we", we_o, 0); chk("rst_re", re_o, 0); chk("rst_err", err_o, 0);
    chk("rst_oe", bus.ebi_rdata_oe, 0); chk("rst_rdata", bus.ebi_rdata, 0);
    chk("rst_addr", addr, 0); chk("rst_wdata", wdata, 0); chk("rst_be", be, 0);
    rst = 1'b0;
    step(2);

    // Full-word write hit: pulse appears on the third edge after cs_n falls
    clr(); start_write(24'h000104, 4'b0000, 32'hDEADBEEF);
    step(2); chk("wr_early", we_cnt, 0);
    step(1); chk("wr_lat", we_o, 1);
    chk("wr_addr", addr, 22'h41); chk("wr_wdata", wdata, 32'hDEADBEEF); chk("wr_be", be, 4'hF);
    step(7); bus_idle(); step(4);
    chk("wr_once", we_cnt, 1); chk("wr_no_re", re_cnt, 0);

    // Byte write with a 50-cycle chip select
    clr(); start_write(24'h000208, 4'b1101, 32'hA5A5A5A5);
    step(50);
    chk("bw_be", be, 4'b0010); chk("bw_once", we_cnt, 1);
    chk("bw_addr", addr, 22'h82); chk("bw_wdata", wdata, 32'hA5A5A5A5);
    bus_idle(); step(4);

    // Read with rvalid_i three cycles after re_o
    clr(); rdata_i = 32'h12345678; start_read(24'h000040);
    step(3); chk("rd_lat", re_o, 1); chk("rd_addr", addr, 22'h10);
    step(3); rvalid_i = 1'b1;
    step(1); rvalid_i = 1'b0;
    chk("rd_data", bus.ebi_rdata, 32'h12345678); chk("rd_oe_pre", bus.ebi_rdata_oe, 0);
    step(1); chk("rd_oe_on", bus.ebi_rdata_oe, 1);
    bus.oe_n = 1'b1;
    step(2); chk("rd_oe_hold", bus.ebi_rdata_oe, 1);
    step(1); chk("rd_oe_off", bus.ebi_rdata_oe, 0);
    bus_idle(); step(4);
    chk("rd_once", re_cnt, 1); chk("rd_no_err", err_cnt, 0);

    // rvalid_i in the same cycle as re_o is accepted
    clr(); rdata_i = 32'hCAFEF00D; rvalid_i = 1'b1; start_read(24'h000044);
    step(3); chk("rv0_re", re_o, 1);
    step(1); chk("rv0_data", bus.ebi_rdata, 32'hCAFEF00D);
    rvalid_i = 1'b0; bus_idle(); step(4);

    // Window miss: read (with a stray rvalid_i) then write
    clr(); rdata_i = 32'h0BADF00D; rvalid_i = 1'b1; start_read(24'h008000);
    step(8);
    chk("miss_rd_re", re_cnt, 0); chk("miss_rd_oe", oe_seen, 0);
    chk("miss_rdata", bus.ebi_rdata, 32'hCAFEF00D);
    rvalid_i = 1'b0; bus_idle(); step(4);
    clr(); start_write(24'h008000, 4'b0000, 32'h11111111);
    step(8);
    chk("miss_wr_we", we_cnt, 0); chk("miss_wdata", wdata, 32'hA5A5A5A5);
    bus_idle(); step(4);

    // Timeout: err_o sixteen cycles after re_o, all-ones driven
    clr(); start_read(24'h000040);
    step(3); chk("to_re", re_o, 1);
    step(15); chk("to_early", err_cnt, 0);
    step(1); chk("to_err", err_o, 1); chk("to_data", bus.ebi_rdata, 32'hFFFFFFFF);
    step(1); chk("to_err_1cyc", err_o, 0); chk("to_oe", bus.ebi_rdata_oe, 1);
    bus_idle(); step(4);

    // Abort: cs_n rises during RWAIT
    clr(); rdata_i = 32'h55555555; start_read(24'h000048);
    step(3); chk("ab_re", re_o, 1);
    step(2); bus_idle();
    step(2); chk("ab_early", err_cnt, 0);
    step(1); chk("ab_err", err_o, 1);
    step(3);
    chk("ab_err_once", err_cnt, 1); chk("ab_no_oe", oe_seen, 0);
    chk("ab_rdata", bus.ebi_rdata, 32'hFFFFFFFF);

    // Reset in the middle of RWAIT
    clr(); start_read(24'h00004C);
    step(3); chk("rr_re", re_o, 1);
    step(2); rst = 1'b1; bus_idle();
    step(1);
    chk("rr_err", err_o, 0); chk("rr_rdata", bus.ebi_rdata, 0);
    chk("rr_addr", addr, 0); chk("rr_oe", bus.ebi_rdata_oe, 0);
    rst = 1'b0; clr();
    step(5);
    chk("rr_quiet", err_cnt + re_cnt + we_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
